fifo_sync_flex: RTL and testbench
=================================

Name:
fifo_sync_flex

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's basic FIFO.
- Adds selectable first-word-fall-through (FWFT) read mode, occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and defined full/empty pass-through behaviour.
- Sits between a producer and a consumer in the same clock domain as the standard buffering element.

Parameters:
- DATA_WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; power of two, minimum 4.
- PTR_SIZE, 5, pointer/count width; equals log2(DEPTH)+1, so the extra MSB distinguishes full from empty.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high reset.
- write_en, input, 1, write request.
- read_en, input, 1, read request (pop).
- data_in, input, DATA_WIDTH, write data.
- clr_err, input, 1, clears the overflow and underflow flags.
- data_out, output, DATA_WIDTH, read data.
- empty, output, 1, FIFO holds 0 words.
- full, output, 1, FIFO holds DEPTH words.
- almost_full, output, 1, count >= AF_THRESH.
- almost_empty, output, 1, count <= AE_THRESH.
- count, output, PTR_SIZE, current occupancy, 0..DEPTH.
- overflow, output, 1, sticky: a write was rejected.
- underflow, output, 1, sticky: a read was rejected.

Behaviour:
- Reset (sampled at clk edge):
  - wr_ptr, rd_ptr, count = 0; data_out = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = 0, underflow = 0.
  - Memory contents are not reset.
  - Reset overrides all other inputs in the same cycle. Reset mid-operation discards all stored data.
- Accept rules, evaluated on registered state at the edge:
  - rd_acc = read_en && !empty.
  - wr_acc = write_en && (!full || rd_acc).
  - Write on full is accepted only when a read is accepted in the same cycle.
  - Read on empty is always rejected, even with a simultaneous write; that write is still accepted.
- Pointers: PTR_SIZE bits wide; low log2(DEPTH) bits address memory; wrap naturally modulo 2*DEPTH.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Flags: empty, full, almost_full and almost_empty are functions of the registered count only, so they change on the same edge as count. No combinational path from inputs to any flag.
- Standard mode (FWFT=0):
  - On rd_acc, data_out loads mem[rd_ptr] at that edge, so data is valid in the cycle after read_en.
  - data_out holds its value otherwise, including on rejected reads.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] whenever empty = 0; the head word is visible before read_en.
  - read_en acknowledges and pops the head word.
  - data_out = 0 while empty.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- Errors:
  - overflow sets on write_en && !wr_acc.
  - underflow sets on read_en && !rd_acc.
  - Both flags are sticky until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the set wins.
- Rejected operations change no pointer, count or memory location.

Test Plan:
- Fill: after reset, write 0x01..0x10 on 16 consecutive cycles -> count increments 1..16; almost_empty deasserts at count 3; almost_full asserts at count 14; full = 1 after the 16th edge; no overflow.
- Overflow: on a full FIFO, write_en=1 with data 0xAA and read_en=0 -> overflow = 1, count stays 16, 0xAA never read back; then clr_err=1 -> overflow = 0.
- Drain (FWFT=0): read 16 times -> data_out = 0x01..0x10, each one cycle after its read_en; empty = 1 after the last read; a 17th read sets underflow and data_out holds 0x10.
- Simultaneous access: on full, read+write 0x55 -> count stays 16, no overflow. On empty, read+write 0x66 -> write accepted, underflow = 1, count = 1.
- Wrap-around: 40 cycles of 1-word-lag streaming with incrementing data -> pointers wrap twice; output sequence matches input with no loss or duplication.
- FWFT=1 instance: write 0x11 to empty -> data_out = 0x11 next cycle without read_en; read_en pops it -> data_out = 0, empty = 1. Assert reset mid-fill at count 5 -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/fifo_sync_flex.sv
// Synchronous single-clock FIFO with a selectable registered or first-word-fall-through read port.
// It also provides an occupancy count, almost-full/empty thresholds and sticky error flags.
module fifo_sync_flex #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PTR_SIZE   = 5,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_SIZE-1:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AW = PTR_SIZE - 1;
  localparam logic [PTR_SIZE-1:0] DepthC = PTR_SIZE'(DEPTH);
  localparam logic [PTR_SIZE-1:0] AfC    = PTR_SIZE'(AF_THRESH);
  localparam logic [PTR_SIZE-1:0] AeC    = PTR_SIZE'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_SIZE-1:0]   occ;
  logic [AW-1:0]         rd_addr;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;

  // Pointers carry an extra wrap bit, so their difference is the occupancy 0..DEPTH.
  assign occ     = wr_ptr_q - rd_ptr_q;
  assign rd_addr = rd_ptr_q[AW-1:0];

  assign count        = occ;
  assign empty        = (occ == '0);
  assign full         = (occ == DepthC);
  assign almost_full  = (occ >= AfC);
  assign almost_empty = (occ <= AeC);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    rd_acc   = read_en && !empty;
    wr_acc   = write_en && (!full || rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_SIZE'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_SIZE'(1) : rd_ptr_q;
    // A new error in the same cycle as clr_err takes priority.
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (write_en && !wr_acc) overflow_d = 1'b1;
    if (read_en && !rd_acc) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : mem_q[rd_addr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
      data_d = rd_acc ? mem_q[rd_addr] : data_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign data_out = data_q;
  end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: a registered-read instance and an FWFT instance, checked against
// a scoreboard queue of words expected to come out in order.
module tb_fifo_sync_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Registered-read instance
  logic       reset, write_en, read_en, clr_err;
  logic [7:0] data_in, data_out;
  logic       empty, full, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  // FWFT instance
  logic       b_reset, b_write_en, b_read_en, b_clr_err;
  logic [7:0] b_data_in, b_data_out;
  logic       b_empty, b_full, b_almost_full, b_almost_empty, b_overflow, b_underflow;
  logic [4:0] b_count;

  logic [7:0] sb[$];
  logic [7:0] b_sb[$];
  logic [7:0] last_out;

  fifo_sync_flex #(.DATA_WIDTH(8), .DEPTH(16), .PTR_SIZE(5), .FWFT(0),
                   .AF_THRESH(14), .AE_THRESH(2)) u_std (
    .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en), .data_in(data_in),
    .clr_err(clr_err), .data_out(data_out), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_flex #(.DATA_WIDTH(8), .DEPTH(16), .PTR_SIZE(5), .FWFT(1),
                   .AF_THRESH(14), .AE_THRESH(2)) u_fwft (
    .clk(clk), .reset(b_reset), .write_en(b_write_en), .read_en(b_read_en),
    .data_in(b_data_in), .clr_err(b_clr_err), .data_out(b_data_out), .empty(b_empty),
    .full(b_full), .almost_full(b_almost_full), .almost_empty(b_almost_empty),
    .count(b_count), .overflow(b_overflow), .underflow(b_underflow)
  );

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; write_en = 1'b1; read_en = 1'b0; data_in = 8'hEE; clr_err = 1'b0;
    b_reset = 1'b1; b_write_en = 1'b0; b_read_en = 1'b0; b_data_in = 8'h00; b_clr_err = 1'b0;
    step();
    step();
    reset = 1'b0; write_en = 1'b0; b_reset = 1'b0;
    checks++;
    if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_flags: got %b, need 110000",
               {empty, almost_empty, full, almost_full, overflow, underflow});
    end
    checks++;
    if (count !== 5'd0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_count_data: got count=%0d data=%h, need 0/00", count, data_out);
    end
    checks++;
    if (b_empty !== 1'b1 || b_count !== 5'd0 || b_data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_fwft: got empty=%b count=%0d data=%h, need 1/0/00",
               b_empty, b_count, b_data_out);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      write_en = 1'b1; data_in = 8'(i);
      sb.push_back(8'(i));
      step();
      checks++;
      if (count !== 5'(i) ||
          {almost_empty, almost_full, full, overflow} !== {i <= 2, i >= 14, i == 16, 1'b0}) begin
        errors++;
        $display("FAIL fill_%0d: got count=%0d ae/af/full/ovf=%b, need %0d %b", i, count,
                 {almost_empty, almost_full, full, overflow}, i,
                 {i <= 2, i >= 14, i == 16, 1'b0});
      end
    end
    write_en = 1'b0;
  endtask

  task automatic test_overflow();
    write_en = 1'b1; data_in = 8'hAA;
    step();
    write_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_set: got ovf=%b count=%0d, need 1/16", overflow, count);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got ovf=%b, need 0", overflow);
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      read_en = 1'b1;
      exp = sb.pop_front();
      step();
      checks++;
      if (data_out !== exp || count !== 5'(15 - i)) begin
        errors++;
        $display("FAIL drain_%0d: got data=%h count=%0d, need %h %0d", i, data_out, count,
                 exp, 15 - i);
      end
      last_out = exp;
    end
    checks++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got empty=%b udf=%b, need 1/0", empty, underflow);
    end
    step();
    read_en = 1'b0;
    checks++;
    if (underflow !== 1'b1 || data_out !== last_out || count !== 5'd0) begin
      errors++;
      $display("FAIL drain_underflow: got udf=%b data=%h count=%0d, need 1 %h 0",
               underflow, data_out, count, last_out);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      write_en = 1'b1; data_in = 8'(8'h20 + i);
      sb.push_back(8'(8'h20 + i));
      step();
    end
    // Full: write accepted only because the read frees a slot in the same cycle.
    write_en = 1'b1; read_en = 1'b1; data_in = 8'h55;
    exp = sb.pop_front();
    sb.push_back(8'h55);
    step();
    write_en = 1'b0; read_en = 1'b0;
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0 || data_out !== exp) begin
      errors++;
      $display("FAIL simul_full: got count=%0d ovf=%b data=%h, need 16 0 %h",
               count, overflow, data_out, exp);
    end
    for (int i = 0; i < 16; i++) begin
      read_en = 1'b1;
      exp = sb.pop_front();
      step();
      checks++;
      if (data_out !== exp) begin
        errors++;
        $display("FAIL simul_drain_%0d: got %h, need %h", i, data_out, exp);
      end
      last_out = exp;
    end
    // Empty: read rejected, write still lands.
    write_en = 1'b1; read_en = 1'b1; data_in = 8'h66;
    step();
    write_en = 1'b0; read_en = 1'b0;
    checks++;
    if (underflow !== 1'b1 || count !== 5'd1 || data_out !== last_out) begin
      errors++;
      $display("FAIL simul_empty: got udf=%b count=%0d data=%h, need 1 1 %h",
               underflow, count, data_out, last_out);
    end
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    checks++;
    if (data_out !== 8'h66 || empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_readback: got data=%h empty=%b, need 66 1", data_out, empty);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    int         model_cnt = 0;
    for (int i = 0; i <= 40; i++) begin
      write_en = (i < 40);
      read_en  = (i > 0);
      data_in  = 8'(8'h80 + i);
      exp      = 8'h00;
      if (read_en && model_cnt > 0) begin
        exp = sb.pop_front();
        model_cnt--;
      end
      if (write_en) begin
        sb.push_back(8'(8'h80 + i));
        model_cnt++;
      end
      step();
      if (i > 0) begin
        checks++;
        if (data_out !== exp || count !== 5'(model_cnt)) begin
          errors++;
          $display("FAIL wrap_%0d: got data=%h count=%0d, need %h %0d", i, data_out, count,
                   exp, model_cnt);
        end
      end
    end
    write_en = 1'b0; read_en = 1'b0;
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: got empty/ovf/udf=%b, need 100", {empty, overflow, underflow});
    end
  endtask

  task automatic test_fwft();
    logic [7:0] exp;
    b_write_en = 1'b1; b_data_in = 8'h11;
    step();
    b_write_en = 1'b0;
    checks++;
    if (b_data_out !== 8'h11 || b_empty !== 1'b0) begin
      errors++;
      $display("FAIL fwft_show: got data=%h empty=%b, need 11 0", b_data_out, b_empty);
    end
    b_read_en = 1'b1;
    step();
    b_read_en = 1'b0;
    checks++;
    if (b_data_out !== 8'h00 || b_empty !== 1'b1) begin
      errors++;
      $display("FAIL fwft_pop: got data=%h empty=%b, need 00 1", b_data_out, b_empty);
    end
    for (int i = 0; i < 3; i++) begin
      b_write_en = 1'b1; b_data_in = 8'(8'hC0 + i);
      b_sb.push_back(8'(8'hC0 + i));
      step();
    end
    b_write_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = b_sb.pop_front();
      checks++;
      if (b_data_out !== exp) begin
        errors++;
        $display("FAIL fwft_head_%0d: got %h, need %h", i, b_data_out, exp);
      end
      b_read_en = 1'b1;
      step();
      b_read_en = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      b_write_en = 1'b1; b_data_in = 8'(8'hD0 + i);
      step();
    end
    checks++;
    if (b_count !== 5'd5 || b_data_out !== 8'hD0) begin
      errors++;
      $display("FAIL fwft_fill5: got count=%0d data=%h, need 5 d0", b_count, b_data_out);
    end
    // Reset with a write still requested: reset must win.
    b_reset = 1'b1;
    step();
    b_reset = 1'b0; b_write_en = 1'b0;
    checks++;
    if (b_count !== 5'd0 || b_data_out !== 8'h00 ||
        {b_empty, b_almost_empty, b_full, b_almost_full, b_overflow, b_underflow} !== 6'b110000)
    begin
      errors++;
      $display("FAIL fwft_midreset: got count=%0d data=%h flags=%b, need 0 00 110000", b_count,
               b_data_out,
               {b_empty, b_almost_empty, b_full, b_almost_full, b_overflow, b_underflow});
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_fwft();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
